// File: rtl/sa_seq_pkg.sv
// Shared definitions for the systolic-array layer sequencer.
//   sa_state_e     : sequencer FSM states (S_ERR only reachable with
//                    SA_SEQ_TIMEOUT_EN defined)
//   DEF_*          : default per-layer ofmap sizes and accumulator beat counts
//   BEAT_W / WD_W  : beat counter and watchdog widths
//   ADDR_W/DATA_W  : BRAM write-port widths
package sa_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_START = 3'd3,
    S_RUN   = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } sa_state_e;

  localparam int DEF_OFMAP0      = 28;
  localparam int DEF_OFMAP1      = 10;
  localparam int DEF_OFMAP2      = 1;
  localparam int DEF_EXP0        = 784;
  localparam int DEF_EXP1        = 100;
  localparam int DEF_EXP2        = 1;
  localparam int DEF_TIMEOUT_CYC = 1000000;

  localparam int BEAT_W = 10;
  localparam int WD_W   = 20;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;

endpackage

// File: rtl/sa_seq_wr_stage.sv
// Registered write-port stage between the host load stream and the array's
// shared BRAM port.
//   clk, rst      : clock, asynchronous active-high reset
//   accept        : a load beat is transferred this cycle
//   addr, data    : address/data of that beat
//   wea           : write enable, high the cycle after each accepted beat
//   addra, dia    : last accepted address/data, held between beats
module sa_seq_wr_stage
  import sa_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dia
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wea   <= 1'b0;
      addra <= '0;
      dia   <= '0;
    end else begin
      wea <= accept;
      if (accept) begin
        addra <= addr;
        dia   <= data;
      end
    end
  end

endmodule

// File: rtl/sa_layer_seq.sv
// Layer sequencer: runs conv layers 0, 1, 2 back to back from one run_i pulse.
// Per layer it opens the host load stream onto the array write port, pulses
// sa_start_o with stable nth_conv_o/ofmap_size_o, then counts accumulator
// beats (accu_valid_i[0]) until the layer's expected count is reached.
//
// Optional feature macro: SA_SEQ_TIMEOUT_EN adds a RUN watchdog (TIMEOUT_CYC)
// with an ERR state and sticky err_o; without it err_o is tied low.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   run_i                    start sequence (honoured only in IDLE)
//   busy_o, done_o           busy outside IDLE/ERR; one-cycle done after layer 2
//   layer_o, nth_conv_o      current layer index
//   ofmap_size_o             ofmap size of the current layer
//   ld_req_i/ld_ready_o      load handshake; ld_addr_i/ld_data_i/ld_last_i payload
//   wea_o, addra_o, dia_o    registered array write port
//   sa_start_o               one-cycle array start pulse
//   accu_valid_i             accumulator valid per column, bit 0 counted
//   err_o                    sticky watchdog error
//   state_o                  FSM state, for debug/observation
//
// Load handshake: a beat transfers on every cycle where ld_req_i && ld_ready_o.
// ld_ready_o depends only on state, never on ld_req_i; the host holds
// addr/data/last stable while ld_req_i is high and not yet accepted.
module sa_layer_seq
  import sa_seq_pkg::*;
#(
  parameter int OFMAP0 = DEF_OFMAP0,
  parameter int OFMAP1 = DEF_OFMAP1,
  parameter int OFMAP2 = DEF_OFMAP2,
  parameter int EXP0   = DEF_EXP0,
  parameter int EXP1   = DEF_EXP1,
  parameter int EXP2   = DEF_EXP2
`ifdef SA_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        layer_o,
  input  logic              ld_req_i,
  output logic              ld_ready_o,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic              ld_last_i,
  output logic              wea_o,
  output logic [ADDR_W-1:0] addra_o,
  output logic [DATA_W-1:0] dia_o,
  output logic              sa_start_o,
  output logic [1:0]        nth_conv_o,
  output logic [4:0]        ofmap_size_o,
  input  logic [15:0]       accu_valid_i,
  output logic              err_o,
  output logic [2:0]        state_o
);

  sa_state_e         state_q, state_d;
  logic [1:0]        layer_q, layer_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [BEAT_W-1:0] exp_m1;
  logic              accept;
  logic              wd_hit;
  logic              accu_unused;

  // Only column 0 paces completion; all columns fire together.
  assign accu_unused = |accu_valid_i[15:1];

  always_comb begin
    exp_m1       = BEAT_W'(EXP2 - 1);
    ofmap_size_o = 5'(OFMAP2);
    case (layer_q)
      2'd0: begin
        exp_m1       = BEAT_W'(EXP0 - 1);
        ofmap_size_o = 5'(OFMAP0);
      end
      2'd1: begin
        exp_m1       = BEAT_W'(EXP1 - 1);
        ofmap_size_o = 5'(OFMAP1);
      end
      default: ;
    endcase
  end

  assign accept = ld_req_i && (state_q == S_LOAD);

`ifdef SA_SEQ_TIMEOUT_EN
  logic [WD_W-1:0] wd_q;
  logic            err_q;

  // wd_q holds the number of completed RUN cycles of this layer.
  assign wd_hit = (wd_q == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == S_START) wd_q <= '0;
      else if (state_q == S_RUN) wd_q <= wd_q + 1'b1;
      if (state_d == S_ERR) err_q <= 1'b1;
      else if (state_q == S_IDLE && run_i) err_q <= 1'b0;
    end
  end

  assign err_o = err_q;
`else
  assign wd_hit = 1'b0;
  assign err_o  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      layer_q <= 2'd0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE: begin
        if (run_i) begin
          state_d = S_LOAD;
          layer_d = 2'd0;
        end
      end
      S_LOAD:  if (accept && ld_last_i) state_d = S_FLUSH;
      // One spare cycle so the final registered write lands before start.
      S_FLUSH: state_d = S_START;
      S_START: begin
        beat_d  = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (accu_valid_i[0]) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == exp_m1) state_d = S_NEXT;
        end else if (wd_hit) begin
          state_d = S_ERR;
        end
      end
      S_NEXT: begin
        if (layer_q == 2'd2) begin
          state_d = S_DONE;
        end else begin
          layer_d = layer_q + 2'd1;
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o     = (state_q != S_IDLE) && (state_q != S_ERR);
  assign done_o     = (state_q == S_DONE);
  assign ld_ready_o = (state_q == S_LOAD);
  assign sa_start_o = (state_q == S_START);
  assign layer_o    = layer_q;
  assign nth_conv_o = layer_q;
  assign state_o    = state_q;

  sa_seq_wr_stage u_wr_stage (
    .clk    (clk),
    .rst    (rst),
    .accept (accept),
    .addr   (ld_addr_i),
    .data   (ld_data_i),
    .wea    (wea_o),
    .addra  (addra_o),
    .dia    (dia_o)
  );

endmodule

// File: tb/tb_sa_layer_seq.sv
// Directed bench for sa_layer_seq. The main process walks the protocol
// cycle by cycle and, for each cycle, pushes the outputs the sequencer must
// show (built from the layer timeline: load beats, flush, start, run beats,
// next, done) onto exp_q; a negedge process compares them.
module tb_sa_layer_seq;

  localparam int E0 = 4;
  localparam int E1 = 2;
  localparam int E2 = 1;

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic        wea;
    logic [16:0] addr;
    logic [7:0]  data;
    logic        start;
    logic        done;
    logic [1:0]  layer;
    logic [4:0]  ofmap;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        run_i;
  logic        busy_o;
  logic        done_o;
  logic [1:0]  layer_o;
  logic        ld_req_i;
  logic        ld_ready_o;
  logic [16:0] ld_addr_i;
  logic [7:0]  ld_data_i;
  logic        ld_last_i;
  logic        wea_o;
  logic [16:0] addra_o;
  logic [7:0]  dia_o;
  logic        sa_start_o;
  logic [1:0]  nth_conv_o;
  logic [4:0]  ofmap_size_o;
  logic [15:0] accu_valid_i;
  logic        err_o;
  logic [2:0]  dbg_state;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  // model of held values
  logic [1:0]  m_layer;
  logic [16:0] m_addr;
  logic [7:0]  m_data;
  logic        m_err;

  // observation of start/done events for literal checks
  int          n_st;
  logic [1:0]  st_nth[4];
  logic [4:0]  st_ofm[4];
  int          n_done;
  int          done_cyc;
  int          last_accu_cyc;

  sa_layer_seq #(
    .EXP0 (E0),
    .EXP1 (E1),
    .EXP2 (E2)
`ifdef SA_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYC (50)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .run_i        (run_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .layer_o      (layer_o),
    .ld_req_i     (ld_req_i),
    .ld_ready_o   (ld_ready_o),
    .ld_addr_i    (ld_addr_i),
    .ld_data_i    (ld_data_i),
    .ld_last_i    (ld_last_i),
    .wea_o        (wea_o),
    .addra_o      (addra_o),
    .dia_o        (dia_o),
    .sa_start_o   (sa_start_o),
    .nth_conv_o   (nth_conv_o),
    .ofmap_size_o (ofmap_size_o),
    .accu_valid_i (accu_valid_i),
    .err_o        (err_o),
    .state_o      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, got no finish, required finish");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, state %0d)",
               name, act, exp, cyc, dbg_state);
    end
  endtask

  function automatic logic [4:0] ofmap_of(input logic [1:0] l);
    case (l)
      2'd0:    return 5'd28;
      2'd1:    return 5'd10;
      default: return 5'd1;
    endcase
  endfunction

  function automatic exp_t mk(input logic b, input logic r, input logic w,
                              input logic s, input logic d);
    exp_t e;
    e.busy  = b;
    e.ready = r;
    e.wea   = w;
    e.addr  = m_addr;
    e.data  = m_data;
    e.start = s;
    e.done  = d;
    e.layer = m_layer;
    e.ofmap = ofmap_of(m_layer);
    e.err   = m_err;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sa_start_o) begin
      if (n_st < 4) begin
        st_nth[n_st] = nth_conv_o;
        st_ofm[n_st] = ofmap_size_o;
      end
      n_st++;
    end
    if (done_o) begin
      n_done++;
      done_cyc = cyc;
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("busy",     busy_o,       e.busy);
      chk("ready",    ld_ready_o,   e.ready);
      chk("wea",      wea_o,        e.wea);
      chk("addra",    addra_o,      e.addr);
      chk("dia",      dia_o,        e.data);
      chk("start",    sa_start_o,   e.start);
      chk("done",     done_o,       e.done);
      chk("layer",    layer_o,      e.layer);
      chk("nth_conv", nth_conv_o,   e.layer);
      chk("ofmap",    ofmap_size_o, e.ofmap);
      chk("err",      err_o,        e.err);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clr_in();
    run_i        = 1'b0;
    ld_req_i     = 1'b0;
    ld_addr_i    = '0;
    ld_data_i    = '0;
    ld_last_i    = 1'b0;
    accu_valid_i = '0;
  endtask

  // Expected outputs e belong to the current cycle; advance to the next.
  task automatic step(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clr_obs();
    n_st   = 0;
    n_done = 0;
  endtask

  task automatic go();
    clr_in();
    run_i = 1'b1;
    step(mk(0, 0, 0, 0, 0));
    run_i   = 1'b0;
    m_layer = 2'd0;
    m_err   = 1'b0;
  endtask

  // n beats at consecutive addresses/data; optional idle gap before beat 1;
  // optional accumulator noise that must be ignored.
  task automatic load_layer(input int n, input logic [16:0] a0, input logic [7:0] d0,
                            input bit gap, input bit noise);
    logic pend;
    pend = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gap && i == 1) begin
        clr_in();
        accu_valid_i = noise ? 16'h0001 : 16'h0000;
        step(mk(1, 1, pend, 0, 0));
        pend = 1'b0;
      end
      clr_in();
      ld_req_i     = 1'b1;
      ld_addr_i    = a0 + 17'(i);
      ld_data_i    = d0 + 8'(i);
      ld_last_i    = (i == n - 1);
      accu_valid_i = noise ? 16'h0001 : 16'h0000;
      step(mk(1, 1, pend, 0, 0));
      pend   = 1'b1;
      m_addr = a0 + 17'(i);
      m_data = d0 + 8'(i);
    end
  endtask

  // FLUSH then START; accumulator beats and run_i here must be ignored.
  task automatic flush_start(input bit pin);
    clr_in();
    accu_valid_i = 16'h0001;
    run_i        = 1'b1;
    if (pin) begin
      chk("lit_wr_wea",   wea_o,   32'd1);
      chk("lit_wr_addra", addra_o, 32'h08005);
      chk("lit_wr_dia",   dia_o,   32'hA5);
    end
    step(mk(1, 0, 1, 0, 0));
    clr_in();
    accu_valid_i = 16'h0001;
    if (pin) chk("lit_start_after_wr", sa_start_o, 32'd1);
    step(mk(1, 0, 0, 1, 0));
    clr_in();
  endtask

  // expn counted beats, each preceded by gap idle cycles; noise drives
  // ld_req_i, run_i and non-counted accumulator columns during the gaps.
  task automatic run_layer(input int expn, input int gap, input bit noise);
    for (int b = 0; b < expn; b++) begin
      for (int g = 0; g < gap; g++) begin
        clr_in();
        if (noise) begin
          ld_req_i     = 1'b1;
          ld_last_i    = 1'b1;
          ld_addr_i    = 17'h1FFFF;
          ld_data_i    = 8'hEE;
          run_i        = 1'b1;
          accu_valid_i = 16'hFFFE;
        end
        step(mk(1, 0, 0, 0, 0));
      end
      clr_in();
      accu_valid_i  = 16'h0001;
      last_accu_cyc = cyc;
      step(mk(1, 0, 0, 0, 0));
    end
    clr_in();
    accu_valid_i = 16'h0001;
    step(mk(1, 0, 0, 0, 0));
    clr_in();
    if (m_layer == 2'd2) step(mk(1, 0, 0, 0, 1));
    else m_layer = m_layer + 2'd1;
  endtask

  task automatic quick_layers();
    load_layer(1, 17'h00200, 8'h30, 0, 0);
    flush_start(0);
    run_layer(E0, 0, 0);
    load_layer(1, 17'h08200, 8'h31, 0, 0);
    flush_start(0);
    run_layer(E1, 0, 0);
    load_layer(1, 17'h08300, 8'h32, 0, 0);
    flush_start(0);
    run_layer(E2, 0, 0);
  endtask

  // ---------------- main ----------------
  initial begin
    clr_in();
    rst     = 1'b1;
    m_layer = 2'd0;
    m_addr  = '0;
    m_data  = '0;
    m_err   = 1'b0;
    clr_obs();
    done_cyc      = 0;
    last_accu_cyc = 0;
    @(posedge clk);
    #1;
    chk("lit_rst_ofmap", ofmap_size_o, 32'd28);
    chk("lit_rst_busy",  busy_o,       32'd0);
    step(mk(0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0));
    rst = 1'b0;
    step(mk(0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0));

    // Full run: 3 beats per layer, noise in load/flush/start/run.
    clr_obs();
    go();
    load_layer(3, 17'h00010, 8'h11, 1, 1);
    flush_start(0);
    run_layer(E0, 1, 1);
    load_layer(3, 17'h08000, 8'h20, 0, 0);
    flush_start(0);
    run_layer(E1, 2, 1);
    load_layer(3, 17'h08003, 8'hA3, 0, 0);
    flush_start(1);
    run_layer(E2, 1, 0);
    step(mk(0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0));
    chk("lit_n_start",   n_st,      32'd3);
    chk("lit_start0_nth", st_nth[0], 32'd0);
    chk("lit_start1_nth", st_nth[1], 32'd1);
    chk("lit_start2_nth", st_nth[2], 32'd2);
    chk("lit_start0_ofm", st_ofm[0], 32'd28);
    chk("lit_start1_ofm", st_ofm[1], 32'd10);
    chk("lit_start2_ofm", st_ofm[2], 32'd1);
    chk("lit_n_done",    n_done,    32'd1);
    chk("lit_done_lat",  done_cyc - last_accu_cyc, 32'd2);

    // Reset in RUN of layer 1.
    go();
    load_layer(1, 17'h00040, 8'h40, 0, 0);
    flush_start(0);
    run_layer(E0, 0, 0);
    load_layer(1, 17'h08040, 8'h41, 0, 0);
    flush_start(0);
    clr_in();
    step(mk(1, 0, 0, 0, 0));
    rst = 1'b1;
    #1;
    chk("lit_rst_mid_layer", layer_o,      32'd0);
    chk("lit_rst_mid_busy",  busy_o,       32'd0);
    chk("lit_rst_mid_wea",   wea_o,        32'd0);
    chk("lit_rst_mid_ofmap", ofmap_size_o, 32'd28);
    chk("lit_rst_mid_addra", addra_o,      32'd0);
    m_layer = 2'd0;
    m_addr  = '0;
    m_data  = '0;
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(mk(0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0));

    // Fresh run after reset completes normally.
    clr_obs();
    go();
    quick_layers();
    step(mk(0, 0, 0, 0, 0));
    chk("lit_fresh_done", n_done, 32'd1);
    chk("lit_fresh_lat",  done_cyc - last_accu_cyc, 32'd2);

`ifdef SA_SEQ_TIMEOUT_EN
    // Watchdog: no accumulator beats for 50 RUN cycles.
    clr_obs();
    go();
    load_layer(1, 17'h00100, 8'h01, 0, 0);
    flush_start(0);
    for (int k = 0; k < 50; k++) step(mk(1, 0, 0, 0, 0));
    m_err = 1'b1;
    step(mk(0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0));
    chk("lit_err_set",  err_o,  32'd1);
    step(mk(0, 0, 0, 0, 0));
    chk("lit_err_no_done", n_done, 32'd0);
    go();
    quick_layers();
    step(mk(0, 0, 0, 0, 0));
    chk("lit_err_clr", err_o, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
